// File: rtl/rtl_kernel_wizard_1_example_run_scheduler.sv
// Run scheduler: ap_ctrl_hs sequencing of a generator-channel bank.
// Launches every channel per round, gathers done pulses, repeats rounds.
module rtl_kernel_wizard_1_example_run_scheduler #(
  parameter int C_NUM_CHANNELS    = 4,
  parameter int C_NUM_ITERATIONS  = 1,
  parameter int C_CYCLE_CNT_WIDTH = 32
) (
  input  logic                         aclk,
  input  logic                         ap_rst_n,
  input  logic                         ap_start,
  output logic                         ap_ready,
  output logic                         ap_done,
  output logic                         ap_idle,
  output logic [C_NUM_CHANNELS-1:0]    ch_start,
  input  logic [C_NUM_CHANNELS-1:0]    ch_done,
  output logic [C_NUM_CHANNELS-1:0]    ch_busy,
  output logic [C_CYCLE_CNT_WIDTH-1:0] cycle_count
);

  localparam int N  = C_NUM_CHANNELS;
  localparam int W  = C_CYCLE_CNT_WIDTH;
  localparam int IW =
    (C_NUM_ITERATIONS > 1) ? $clog2(C_NUM_ITERATIONS) : 1;
  localparam logic [IW-1:0] LAST_ITER =
    IW'(C_NUM_ITERATIONS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [N-1:0]   r_lat;
  logic [N-1:0]   r_busy;
  logic [IW-1:0]  r_iter;
  logic [W-1:0]   r_cc;
  logic [W-1:0]   w_cc_inc;
  logic           w_all_done;
  logic           w_last;

  // Pulses arriving this cycle count toward completion.
  assign w_all_done = &(r_lat | ch_done);
  assign w_last     = (r_iter == LAST_ITER);
  assign w_cc_inc   = (r_cc == {W{1'b1}}) ? r_cc : r_cc + W'(1);

  // State register.
  always_ff @(posedge aclk) begin
    if (!ap_rst_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (ap_start) w_next = S_START;
      S_START: w_next = S_BUSY;
      S_BUSY: begin
        if (w_all_done) w_next = w_last ? S_DONE : S_START;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Round bookkeeping: done latches, busy mask, iterations, run length.
  always_ff @(posedge aclk) begin
    if (!ap_rst_n) begin
      r_lat  <= '0;
      r_busy <= '0;
      r_iter <= '0;
      r_cc   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (ap_start) begin
            r_iter <= '0;
            r_cc   <= '0;
          end
        end
        S_START: begin
          r_lat  <= '0;
          r_busy <= '1;
          r_cc   <= w_cc_inc;
        end
        S_BUSY: begin
          r_lat  <= r_lat | ch_done;
          r_busy <= r_busy & ~ch_done;
          r_cc   <= w_cc_inc;
          if (w_all_done && !w_last) r_iter <= r_iter + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign ch_start    = {N{r_state == S_START}};
  assign ap_done     = (r_state == S_DONE);
  assign ap_ready    = (r_state == S_DONE);
  assign ap_idle     = (r_state == S_IDLE);
  assign ch_busy     = r_busy;
  assign cycle_count = r_cc;

endmodule
